fetch_ctrl: RTL

- Instruction-fetch controller for the 5-stage pipeline.
- Owns the PC, issues reads to the (possibly multi-cycle) instruction memory, and drives the fetch side of the IF/ID latch: instruction, next_pc1, write enable, and NOP-inject stall.
- Absorbs memory latency, hazard stalls, branch redirects and HALT, so IF/ID only ever latches a valid instruction or a NOP bubble.

---
 rtl/fetch_ctrl_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 12 +
 rtl/fetch_buf.sv | 24 ++
 rtl/fetch_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: IF/ID word, fetch FSM encoding, default constants.
package fetch_ctrl_pkg;
  typedef logic [15:0] word_t;
  typedef logic [1:0]  fstate_t;

  localparam fstate_t FETCH  = 2'd0;
  localparam fstate_t WAIT   = 2'd1;
  localparam fstate_t DRAIN  = 2'd2;
  localparam fstate_t HALTED = 2'd3;

  localparam word_t NOP_WORD = 16'h0800;
  localparam word_t PC_STEP  = 16'h0002;

  // Fetch-side view of the IF/ID latch inputs.
  typedef struct packed {
    word_t instr;
    word_t next_pc1;
    logic  en;
    logic  stall;
  } ifid_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory request/response bus between fetch and imem.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;
  word_t mem_addr;
  logic  mem_rd;
  word_t mem_data;
  logic  mem_done;
  logic  mem_stall;

  modport master (output mem_addr, mem_rd, input mem_data, mem_done, mem_stall);
  modport slave  (input mem_addr, mem_rd, output mem_data, mem_done, mem_stall);
endinterface

// File: rtl/fetch_buf.sv
// One-entry holding register for a word fetched while decode is stalled.
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clr,
  input  word_t d,
  output word_t q,
  output logic  valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns PC, issues single-outstanding imem reads, feeds IF/ID.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter word_t RESET_PC  = 16'h0000,
  parameter word_t NOP_INSTR = NOP_WORD,
  parameter word_t PC_INC    = PC_STEP
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_in,
  input  logic         redirect,
  input  word_t        redirect_pc,
  input  logic         halt,
  fetch_ctrl_if.master mem,
  output word_t        pc,
  output word_t        instruction,
  output word_t        next_pc1,
  output logic         ifid_en,
  output logic         fetch_stall
);
  fstate_t state, state_nx;
  word_t   pc_nx, tgt, tgt_nx, word, buf_q;
  logic    hpend, hpend_nx;
  logic    buf_vld, buf_load, buf_clr;
  logic    issue, from_buf, have_word, pending;
  ifid_t   ifid;

  fetch_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clr   (buf_clr),
    .d     (mem.mem_data),
    .q     (buf_q),
    .valid (buf_vld)
  );

  assign issue     = (state == FETCH) && !buf_vld;
  assign from_buf  = (state == FETCH) && buf_vld;
  assign have_word = from_buf || ((issue || state == WAIT) && mem.mem_done);
  assign word      = from_buf ? buf_q : mem.mem_data;
  // An access that will still be outstanding after this edge.
  assign pending   = (issue && mem.mem_stall && !mem.mem_done) ||
                     ((state == WAIT || state == DRAIN) && !mem.mem_done);

  assign mem.mem_rd   = issue && !rst;
  assign mem.mem_addr = pc;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    tgt_nx   = tgt;
    hpend_nx = hpend;
    buf_load = 1'b0;
    buf_clr  = 1'b0;
    ifid     = '{instr: NOP_INSTR, next_pc1: pc + PC_INC, en: 1'b1, stall: 1'b1};
    if (rst || state == HALTED) begin
      // bubble only; HALTED is left solely through reset
    end else if (redirect) begin
      buf_clr  = 1'b1;
      hpend_nx = 1'b0;
      if (pending) begin
        state_nx = DRAIN;
        tgt_nx   = redirect_pc;
      end else begin
        state_nx = FETCH;
        pc_nx    = redirect_pc;
      end
    end else if (halt) begin
      buf_clr  = 1'b1;
      state_nx = pending ? DRAIN : HALTED;
      if (pending) hpend_nx = 1'b1;
    end else if (state == DRAIN) begin
      if (mem.mem_done) begin
        if (hpend) begin
          state_nx = HALTED;
        end else begin
          state_nx = FETCH;
          pc_nx    = tgt;
        end
      end
    end else if (have_word) begin
      state_nx = FETCH;
      if (stall_in) begin
        ifid.en = 1'b0;
        if (!from_buf) buf_load = 1'b1;
      end else begin
        ifid.instr = word;
        ifid.stall = 1'b0;
        pc_nx      = pc + PC_INC;
        buf_clr    = from_buf;
      end
    end else begin
      if (issue && mem.mem_stall) state_nx = WAIT;
      if (stall_in) ifid.en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      tgt   <= RESET_PC;
      hpend <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      tgt   <= tgt_nx;
      hpend <= hpend_nx;
    end
  end

  assign instruction = ifid.instr;
  assign next_pc1    = ifid.next_pc1;
  assign ifid_en     = ifid.en;
  assign fetch_stall = ifid.stall;
endmodule
